median_frame_writer: RTL and testbench

Downstream sink for the median filter output stream. After `start_i` it captures exactly one frame of IMAGE_LEN × IMAGE_HEIGHT pixels from a `pixel_valid_if` stream and writes them in raster order to a single-port frame RAM through a registered write port. It also keeps a running checksum and a sticky flag for stray pixels. It signals frame completion with a one-cycle pulse, and its write port is the point where frame-buffer contents are checked.

---
 rtl/pixel_valid_if.sv | 9 +
 rtl/median_frame_writer.sv | 89 ++++++++
 tb/tb_median_frame_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pixel_valid_if.sv
// pixel_valid_if: valid-qualified pixel stream with no backpressure
// valid : pixel is meaningful this cycle
// pixel : PIXEL_W-bit pixel value
interface pixel_valid_if #(parameter int PIXEL_W = 8);
  logic               valid;
  logic [PIXEL_W-1:0] pixel;
  modport master (output valid, pixel);
  modport slave  (input  valid, pixel);
endinterface

// File: rtl/median_frame_writer.sv
// median_frame_writer: captures one raster frame from a pixel stream into a frame RAM write port
// clk, rst (sync, active-low) | start_i arms one frame | pixel_valid_if_i input stream
// wr_en_o/wr_addr_o/wr_data_o registered RAM write port | busy_o high in CAPTURE
// frame_done_o pulses with the last write | checksum_o running pixel sum | stray_o sticky out-of-frame pixel flag
module median_frame_writer #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int ADDR_W       = $clog2(IMAGE_LEN*IMAGE_HEIGHT),
  parameter int PIXEL_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  pixel_valid_if.slave        pixel_valid_if_i,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [PIXEL_W-1:0]  wr_data_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [31:0]         checksum_o,
  output logic                stray_o
);
  localparam int CW = IMAGE_LEN > 1 ? $clog2(IMAGE_LEN) : 1;
  localparam int RW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_LEN-1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMAGE_HEIGHT-1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [PIXEL_W-1:0] wr_data_q, wr_data_d;
  logic [31:0] csum_q, csum_d;
  logic wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, stray_q, stray_d;
  logic go, acc, last, adv;
  always_comb begin
    go        = state_q == IDLE && start_i;
    acc       = state_q == CAPTURE && pixel_valid_if_i.valid;
    last      = col_q == COL_MAX && row_q == ROW_MAX;
    // counters park on the final pixel so the address never runs past the frame
    adv       = acc && !last;
    state_d   = go ? CAPTURE : (acc && last) ? DONE : state_q == DONE ? IDLE : state_q;
    col_d     = go ? '0 : adv ? (col_q == COL_MAX ? '0 : col_q + 1'b1) : col_q;
    row_d     = go ? '0 : (adv && col_q == COL_MAX) ? row_q + 1'b1 : row_q;
    addr_d    = go ? '0 : adv ? addr_q + 1'b1 : addr_q;
    wr_en_d   = acc;
    wr_addr_d = acc ? addr_q : wr_addr_q;
    wr_data_d = acc ? pixel_valid_if_i.pixel : wr_data_q;
    busy_d    = state_d == CAPTURE;
    done_d    = acc && last;
    csum_d    = go ? '0 : acc ? csum_q + 32'(pixel_valid_if_i.pixel) : csum_q;
    // a pixel arriving in the same cycle as start is still stray, so set beats clear
    stray_d   = (pixel_valid_if_i.valid && state_q != CAPTURE) || (stray_q && !go);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      csum_q    <= '0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      csum_q    <= csum_d;
      stray_q   <= stray_d;
    end
  end
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign checksum_o   = csum_q;
  assign stray_o      = stray_q;
endmodule

// File: tb/tb_median_frame_writer.sv
// tb_median_frame_writer: scoreboard bench for median_frame_writer on a 4x3 frame
module tb_median_frame_writer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic wr_en_o, busy_o, frame_done_o, stray_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [31:0] checksum_o;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dones = 0;
  int exp_addr = 0;
  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic       dn;
    int         c;
  } exp_t;
  exp_t q[$];
  pixel_valid_if #(.PIXEL_W(8)) pif ();
  median_frame_writer #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3), .ADDR_W(4), .PIXEL_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pixel_valid_if_i(pif.slave),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .checksum_o(checksum_o), .stray_o(stray_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (frame_done_o === 1'b1) dones++;
    if (wr_en_o === 1'b1) begin
      if (q.size() == 0) chk("unexpected_write", 32'(wr_addr_o), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.a));
        chk("wr_data", 32'(wr_data_o), 32'(e.d));
        chk("wr_done", 32'(frame_done_o), 32'(e.dn));
        chk("wr_cycle", cyc, e.c);
      end
    end else if (frame_done_o === 1'b1) chk("done_without_write", 32'(frame_done_o), 32'd0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic px(input logic [7:0] p, input int gap);
    pif.valid = 1'b1;
    pif.pixel = p;
    q.push_back('{a: 4'(exp_addr), d: p, dn: exp_addr == 11, c: cyc + 1});
    exp_addr++;
    tick();
    pif.valid = 1'b0;
    repeat (gap) tick();
  endtask
  task automatic start_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    exp_addr = 0;
  endtask
  task automatic stray_px();
    pif.valid = 1'b1;
    pif.pixel = 8'hFF;
    tick();
    pif.valid = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr_o), 0);
    chk({tag, "_wr_data"}, 32'(wr_data_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(frame_done_o), 0);
    chk({tag, "_checksum"}, checksum_o, 0);
    chk({tag, "_stray"}, 32'(stray_o), 0);
  endtask
  initial begin
    int gaps[12] = '{1, 0, 3, 2, 0, 1, 3, 0, 2, 1, 0, 3};
    pif.valid = 1'b0;
    pif.pixel = 8'h00;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();
    stray_px();
    tick();
    chk("stray_idle", 32'(stray_o), 1);
    chk("stray_idle_checksum", checksum_o, 0);
    start_frame();
    chk("start_busy", 32'(busy_o), 1);
    chk("start_clears_stray", 32'(stray_o), 0);
    for (int k = 0; k < 12; k++) px(8'(k), 0);
    chk("cont_busy_fall", 32'(busy_o), 0);
    chk("cont_done", 32'(frame_done_o), 1);
    stray_px();
    chk("cont_done_single", 32'(frame_done_o), 0);
    chk("stray_done", 32'(stray_o), 1);
    chk("cont_checksum", checksum_o, 66);
    tick();
    chk("stray_done_checksum", checksum_o, 66);
    chk("stray_hold", 32'(stray_o), 1);
    start_frame();
    chk("restart_clears_stray", 32'(stray_o), 0);
    for (int k = 0; k < 12; k++) px(8'(k), gaps[k]);
    repeat (2) tick();
    chk("gap_checksum", checksum_o, 66);
    chk("gap_idle_busy", 32'(busy_o), 0);
    start_frame();
    for (int k = 0; k < 12; k++) begin
      start_i = (k == 5);
      px(8'(k), 0);
    end
    start_i = 1'b0;
    repeat (2) tick();
    chk("ignored_start_checksum", checksum_o, 66);
    start_frame();
    for (int k = 0; k < 7; k++) px(8'(k), 0);
    rst = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    tick();
    chk_reset_outputs("midreset_hold");
    rst = 1'b1;
    tick();
    chk("post_reset_busy", 32'(busy_o), 0);
    start_frame();
    for (int k = 0; k < 12; k++) px(8'(100 + k), 0);
    chk("reset_frame_checksum", checksum_o, 1266);
    tick();
    tick();
    start_i = 1'b1;
    tick();
    exp_addr = 0;
    for (int k = 0; k < 12; k++) px(8'(k), 0);
    chk("b2b_first_checksum", checksum_o, 66);
    tick();
    tick();
    chk("b2b_second_busy", 32'(busy_o), 1);
    chk("b2b_checksum_restart", checksum_o, 0);
    exp_addr = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) start_i = 1'b0;
      px(8'(20 + k), 0);
    end
    chk("b2b_second_checksum", checksum_o, 306);
    repeat (3) tick();
    chk("b2b_idle", 32'(busy_o), 0);
    chk("queue_empty", q.size(), 0);
    chk("done_pulses", dones, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
